// File: rtl/aes256_inv_key_sched.sv
// Reverse AES-256 key schedule.
// Loaded with w[52..59], it regenerates the expanded key backwards one word
// per cycle and streams round keys 14 down to 0 over a valid/ready handshake.
module aes256_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OUT,
        S_GEN
    } state_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bit 2047 - 8*b, which is {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    // Round constant for word index i = 8*k.
    function automatic logic [7:0] rcon(input logic [2:0] k);
        logic [7:0] r;
        case (k)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] win_q [8];   // win_q[k] holds w[i-7+k]
    logic [31:0] win_d [8];
    logic [5:0]  idx_q, idx_d;   // word index i of win_q[7]
    logic [3:0]  rnd_q, rnd_d;
    logic [1:0]  step_q, step_d;
    logic        done_q, done_d;

    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t_word;
    logic [31:0] new_word;

    // SubWord input: RotWord is applied first only on i mod 8 = 0 steps.
    always_comb begin
        if (idx_q[2:0] == 3'd0) begin
            sub_in = {win_q[6][23:0], win_q[6][31:24]};
        end else begin
            sub_in = win_q[6];
        end
    end

    // The four shared S-box lookups.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        sub_out = '0;
        for (int b = 0; b < 4; b++) begin
            sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
        end
    end

    // Backward step: w[i-8] = w[i] ^ T(w[i-1], i).
    always_comb begin
        case (idx_q[2:0])
            3'd0:    t_word = sub_out ^ {rcon(idx_q[5:3]), 24'h000000};
            3'd4:    t_word = sub_out;
            default: t_word = win_q[6];
        endcase
        new_word = win_q[7] ^ t_word;
    end

    // Next-state logic for the control FSM and the word window.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 8; k++) begin
                        win_d[k] = key_in[32*(7-k) +: 32];
                    end
                    idx_d   = 6'd59;
                    rnd_d   = 4'd14;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd14) begin
                        // Round 13 is already in the low half of the window.
                        rnd_d = 4'd13;
                    end else if (rnd_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        step_d  = 2'd0;
                        state_d = S_GEN;
                    end
                end
            end
            S_GEN: begin
                win_d[0] = new_word;
                for (int k = 1; k < 8; k++) begin
                    win_d[k] = win_q[k-1];
                end
                idx_d  = idx_q - 6'd1;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    rnd_d   = rnd_q - 4'd1;
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            // NOTE: the window is reset because round_key is driven straight from it and must read 0 after reset.
            for (int k = 0; k < 8; k++) begin
                win_q[k] <= '0;
            end
            idx_q  <= '0;
            rnd_q  <= '0;
            step_q <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign rk_valid  = (state_q == S_OUT);
    assign round_idx = rnd_q;
    assign done      = done_q;
    // Round 14 sits in the upper half of the freshly loaded window; every
    // later round is formed in the lower half after its four GEN steps.
    assign round_key = (rnd_q == 4'd14) ? {win_q[4], win_q[5], win_q[6], win_q[7]}
                                        : {win_q[0], win_q[1], win_q[2], win_q[3]};

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Self-checking bench for aes256_inv_key_sched against a forward-expansion model.
module tb_aes256_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic         ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    aes256_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .ready     (ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // Forward key expansion model
    logic [31:0] mw [60];

    function automatic logic [31:0] subw(input logic [31:0] x);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            int unsigned p;
            p = 2047 - 8 * int'(x[8*b +: 8]);
            r[8*b +: 8] = SBOX_T[p -: 8];
        end
        return r;
    endfunction

    task automatic model_expand(input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) mw[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = mw[i-1];
            if (i % 8 == 0) begin
                rc = 8'h01 << (i/8 - 1);
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    function automatic logic [255:0] model_key_in();
        return {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom();
        return k;
    endfunction

    // Observations from the most recent stream
    logic [127:0] got_key [15];
    logic [3:0]   got_idx [15];
    int           n_got, done_cnt, done_k, r0_edge;
    int           hold_viol, gap_viol, ready_viol;
    logic         valid_at_k0;
    logic [3:0]   idx_at_k0;
    logic         ready_at_done;

    // Loads a key (unless the caller already raised start) and consumes the stream.
    // k counts rising edges since the one that sampled start; all sampling is on negedges.
    task automatic run_stream(input logic [255:0] kin, input int pct, input bit preloaded,
                              input bit poke_start, input int abort_idx,
                              input bit restart, input logic [255:0] rkey);
        bit          await_key, hold_prev, fin, abort_pending;
        int          gap;
        logic [127:0] pk;
        logic [3:0]  pi;
        int          last_idx;
        n_got = 0; done_cnt = 0; done_k = -1; r0_edge = -1;
        hold_viol = 0; gap_viol = 0; ready_viol = 0; ready_at_done = 1'b0;
        if (!preloaded) begin
            @(negedge clk);
            key_in = kin;
            start  = 1'b1;
        end
        @(negedge clk);
        start       = 1'b0;
        rk_ready    = 1'b0;
        valid_at_k0 = rk_valid;
        idx_at_k0   = round_idx;
        await_key = 1'b1; gap = 0; last_idx = 15; hold_prev = 1'b0;
        fin = 1'b0; abort_pending = 1'b0; pk = '0; pi = '0;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);
            start = 1'b0;
            if (abort_pending) begin
                rk_ready = 1'b0;
                return;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (fin && k == r0_edge) ready_at_done = (ready === 1'b1);
            if (!fin && ready !== 1'b0) ready_viol++;
            if (hold_prev && (rk_valid !== 1'b1 || round_key !== pk || round_idx !== pi)) hold_viol++;
            if (!fin) begin
                if (rk_valid === 1'b1) begin
                    if (await_key) begin
                        if (gap != ((last_idx >= 14) ? 0 : 4)) gap_viol++;
                        await_key = 1'b0;
                    end
                end else if (await_key) begin
                    gap++;
                end
            end
            if (fin && k == r0_edge && restart) begin
                key_in = rkey;
                start  = 1'b1;
                return;
            end
            if (fin && k >= r0_edge + 3) break;
            if (poke_start && (k == 10 || k == 30)) begin
                start  = 1'b1;
                key_in = ~kin;
            end
            rk_ready  = !fin && ($urandom_range(99) < pct);
            hold_prev = (rk_valid === 1'b1) && !rk_ready;
            pk = round_key;
            pi = round_idx;
            if (rk_valid === 1'b1 && rk_ready) begin
                if (n_got < 15) begin
                    got_key[n_got] = round_key;
                    got_idx[n_got] = round_idx;
                end
                n_got++;
                last_idx  = int'(round_idx);
                await_key = 1'b1;
                gap       = 0;
                if (round_idx == 4'd0) begin
                    fin     = 1'b1;
                    r0_edge = k + 1;
                end
                if (int'(round_idx) == abort_idx) abort_pending = 1'b1;
            end
        end
        rk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        #12;
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rk_valid: got %b want 0", rk_valid); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (round_key !== 128'h0) begin tests_failed++; $display("FAIL reset_round_key: got %h want 0", round_key); end
        tests_run++; if (round_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        model_expand(FIPS_KEY);
        run_stream(model_key_in(), 100, 1'b0, 1'b0, -1, 1'b0, '0);
        tests_run++; if (valid_at_k0 !== 1'b1 || idx_at_k0 !== 4'd14) begin tests_failed++; $display("FAIL fips_first_key_latency: valid %b idx %0d want 1 14", valid_at_k0, idx_at_k0); end
        tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL fips_key_count: got %0d want 15", n_got); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_idx[j] !== 4'(14 - j) || got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL fips_round%0d: got idx %0d key %h want idx %0d key %h", 14 - j, got_idx[j], got_key[j], 14 - j, exp_rk(14 - j)); end
        end
        tests_run++; if (got_key[0] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin tests_failed++; $display("FAIL fips_round14_const: got %h", got_key[0]); end
        tests_run++; if (got_key[13] !== 128'h101112131415161718191a1b1c1d1e1f) begin tests_failed++; $display("FAIL fips_round1_const: got %h", got_key[13]); end
        tests_run++; if (got_key[14] !== 128'h000102030405060708090a0b0c0d0e0f) begin tests_failed++; $display("FAIL fips_round0_const: got %h", got_key[14]); end
        tests_run++; if (r0_edge != 67) begin tests_failed++; $display("FAIL fips_round0_edge: got %0d want 67", r0_edge); end
        tests_run++; if (done_cnt != 1 || done_k != 67) begin tests_failed++; $display("FAIL fips_done_pulse: count %0d at %0d want 1 at 67", done_cnt, done_k); end
        tests_run++; if (ready_at_done !== 1'b1) begin tests_failed++; $display("FAIL fips_ready_with_done: got %b want 1", ready_at_done); end
        tests_run++; if (gap_viol != 0) begin tests_failed++; $display("FAIL fips_gen_gaps: got %0d bad gaps want 0", gap_viol); end
        tests_run++; if (ready_viol != 0) begin tests_failed++; $display("FAIL fips_ready_busy: got %0d cycles ready want 0", ready_viol); end
    endtask

    task automatic test_backpressure();
        model_expand(FIPS_KEY);
        run_stream(model_key_in(), 30, 1'b0, 1'b0, -1, 1'b0, '0);
        tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL bp_key_count: got %0d want 15", n_got); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_idx[j] !== 4'(14 - j) || got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL bp_round%0d: got idx %0d key %h want %h", 14 - j, got_idx[j], got_key[j], exp_rk(14 - j)); end
        end
        tests_run++; if (hold_viol != 0) begin tests_failed++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_viol); end
        tests_run++; if (gap_viol != 0) begin tests_failed++; $display("FAIL bp_gen_gaps: got %0d bad gaps want 0", gap_viol); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        model_expand(FIPS_KEY);
        run_stream(model_key_in(), 100, 1'b0, 1'b1, -1, 1'b0, '0);
        tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL busy_start_key_count: got %0d want 15", n_got); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL busy_start_round%0d: got %h want %h", 14 - j, got_key[j], exp_rk(14 - j)); end
        end
        tests_run++; if (ready_viol != 0) begin tests_failed++; $display("FAIL busy_start_ready: got %0d cycles ready want 0", ready_viol); end
    endtask

    task automatic test_reset_mid();
        logic [255:0] k2;
        model_expand(FIPS_KEY);
        run_stream(model_key_in(), 100, 1'b0, 1'b0, 9, 1'b0, '0);
        tests_run++; if (n_got != 6) begin tests_failed++; $display("FAIL midrst_keys_before: got %0d want 6", n_got); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (rk_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_rk_valid: got %b want 0", rk_valid); end
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready: got %b want 1", ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (rk_valid !== 1'b0 || round_idx !== 4'd0) begin tests_failed++; $display("FAIL midrst_no_partial: got valid %b idx %0d want 0 0", rk_valid, round_idx); end
        k2 = rand_key();
        model_expand(k2);
        run_stream(model_key_in(), 100, 1'b0, 1'b0, -1, 1'b0, '0);
        tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL midrst_reload_count: got %0d want 15", n_got); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_idx[j] !== 4'(14 - j) || got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL midrst_reload_round%0d: got %h want %h", 14 - j, got_key[j], exp_rk(14 - j)); end
        end
    endtask

    task automatic test_random_keys();
        logic [255:0] k;
        for (int n = 0; n < 200; n++) begin
            k = rand_key();
            model_expand(k);
            run_stream(model_key_in(), 100, 1'b0, 1'b0, -1, 1'b0, '0);
            tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL rand%0d_count: got %0d want 15", n, n_got); end
            for (int j = 0; j < 15 && j < n_got; j++) begin
                tests_run++; if (got_idx[j] !== 4'(14 - j) || got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL rand%0d_round%0d: got %h want %h key %h", n, 14 - j, got_key[j], exp_rk(14 - j), k); end
            end
        end
    endtask

    task automatic test_restart_on_done();
        logic [255:0] ka, kb, kb_in;
        ka = rand_key();
        kb = rand_key();
        model_expand(kb);
        kb_in = model_key_in();
        model_expand(ka);
        run_stream(model_key_in(), 100, 1'b0, 1'b0, -1, 1'b1, kb_in);
        tests_run++; if (n_got != 15 || done_k != r0_edge) begin tests_failed++; $display("FAIL restart_first: count %0d done at %0d want 15 at %0d", n_got, done_k, r0_edge); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL restart_first_round%0d: got %h want %h", 14 - j, got_key[j], exp_rk(14 - j)); end
        end
        model_expand(kb);
        run_stream(kb_in, 100, 1'b1, 1'b0, -1, 1'b0, '0);
        tests_run++; if (valid_at_k0 !== 1'b1 || idx_at_k0 !== 4'd14) begin tests_failed++; $display("FAIL restart_latency: valid %b idx %0d want 1 14", valid_at_k0, idx_at_k0); end
        tests_run++; if (n_got != 15) begin tests_failed++; $display("FAIL restart_second_count: got %0d want 15", n_got); end
        for (int j = 0; j < 15 && j < n_got; j++) begin
            tests_run++; if (got_idx[j] !== 4'(14 - j) || got_key[j] !== exp_rk(14 - j)) begin tests_failed++; $display("FAIL restart_second_round%0d: got %h want %h", 14 - j, got_key[j], exp_rk(14 - j)); end
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_random_keys();
        test_restart_on_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hang guard; every wait above is already bounded.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
